window_average: RTL and testbench

- Boxcar moving-sum/average stage directly downstream of delay_sample.
- Consumes each live sample plus the same sample delayed by 2^WINDOW_SHIFT valid beats (delay_sample output). Maintains a running window sum as sum += new − oldest.
- Emits the sum and the mean (sum >> WINDOW_SHIFT) once the window has filled.
- Feeds decimation/threshold logic that needs a smoothed stream.

---
 rtl/window_average.sv | 118 +++++++++++
 tb/tb_window_average.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_average.sv
// window_average: boxcar moving sum / mean over 2^WINDOW_SHIFT valid beats.
// Runs after an upstream delay line that supplies each sample again N beats
// later. The sum fills first and then slides as sum += new - oldest.
module window_average #(
   parameter int DATA_WIDTH   = 32,
   parameter int WINDOW_SHIFT = 9
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               clear,
   input  logic                               input_valid,
   input  logic [DATA_WIDTH-1:0]              data_in,
   input  logic [DATA_WIDTH-1:0]              data_delayed,
   output logic                               output_valid,
   output logic [DATA_WIDTH+WINDOW_SHIFT-1:0] sum_out,
   output logic [DATA_WIDTH-1:0]              mean_out,
   output logic                               window_full
);

   localparam int SUM_WIDTH = DATA_WIDTH + WINDOW_SHIFT;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  r_state,    w_state_nxt;
   logic [WINDOW_SHIFT-1:0] r_fill_cnt, w_fill_cnt_nxt;
   logic [SUM_WIDTH-1:0]    r_acc,      w_acc_nxt;
   logic [SUM_WIDTH-1:0]    r_sum,      w_sum_nxt;
   logic [DATA_WIDTH-1:0]   r_mean,     w_mean_nxt;
   logic                    r_ov,       w_ov_nxt;

   logic [SUM_WIDTH-1:0]    w_din_ext;
   logic [SUM_WIDTH-1:0]    w_del_ext;
   logic [SUM_WIDTH-1:0]    w_acc_fill;
   logic [SUM_WIDTH-1:0]    w_acc_slide;

   assign w_din_ext   = {{WINDOW_SHIFT{1'b0}}, data_in};
   assign w_del_ext   = {{WINDOW_SHIFT{1'b0}}, data_delayed};
   assign w_acc_fill  = r_acc + w_din_ext;
   // Modular in SUM_WIDTH; aligned upstream data keeps it non-negative.
   assign w_acc_slide = r_acc + w_din_ext - w_del_ext;

   // Next-state, accumulator and output-register update logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_fill_cnt_nxt = r_fill_cnt;
      w_acc_nxt      = r_acc;
      w_sum_nxt      = r_sum;
      w_mean_nxt     = r_mean;
      w_ov_nxt       = 1'b0;
      if (enable) begin
         if (clear) begin
            // Restart the window; the coincident sample is dropped and the
            // published sum/mean keep their last values.
            w_state_nxt    = ST_FILL;
            w_fill_cnt_nxt = '0;
            w_acc_nxt      = '0;
         end else if (input_valid) begin
            case (r_state)
               ST_FILL: begin
                  w_acc_nxt      = w_acc_fill;
                  w_fill_cnt_nxt = r_fill_cnt + 1'b1;
                  if (r_fill_cnt == '1) begin
                     w_state_nxt = ST_RUN;
                     w_ov_nxt    = 1'b1;
                     w_sum_nxt   = w_acc_fill;
                     w_mean_nxt  = w_acc_fill[SUM_WIDTH-1:WINDOW_SHIFT];
                  end
               end
               ST_RUN: begin
                  w_acc_nxt  = w_acc_slide;
                  w_ov_nxt   = 1'b1;
                  w_sum_nxt  = w_acc_slide;
                  w_mean_nxt = w_acc_slide[SUM_WIDTH-1:WINDOW_SHIFT];
               end
               default: begin
                  w_state_nxt = ST_FILL;
               end
            endcase
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fill counter, accumulator and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fill_cnt <= '0;
         r_acc      <= '0;
         r_sum      <= '0;
         r_mean     <= '0;
         r_ov       <= 1'b0;
      end else begin
         r_fill_cnt <= w_fill_cnt_nxt;
         r_acc      <= w_acc_nxt;
         r_sum      <= w_sum_nxt;
         r_mean     <= w_mean_nxt;
         r_ov       <= w_ov_nxt;
      end
   end

   assign output_valid = r_ov;
   assign sum_out      = r_sum;
   assign mean_out     = r_mean;
   assign window_full  = (r_state == ST_RUN);

endmodule

// File: tb/tb_window_average.sv
// Bench for window_average: a WINDOW_SHIFT=2 instance checked against a
// sample-history model (sum of the last N accepted samples), plus a
// WINDOW_SHIFT=9 instance driven with full-scale constant data.
module tb_window_average;

   localparam int DW  = 32;
   localparam int SA  = 2;
   localparam int NA  = 4;
   localparam int SB  = 9;
   localparam int NB  = 512;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Instance A (N = 4)
   logic             a_en, a_clr, a_v;
   logic [DW-1:0]    a_din, a_del;
   logic             a_ov, a_wf;
   logic [DW+SA-1:0] a_sum;
   logic [DW-1:0]    a_mean;

   // Instance B (N = 512)
   logic             b_en, b_clr, b_v;
   logic [DW-1:0]    b_din, b_del;
   logic             b_ov, b_wf;
   logic [DW+SB-1:0] b_sum;
   logic [DW-1:0]    b_mean;

   window_average #(.DATA_WIDTH(DW), .WINDOW_SHIFT(SA)) u_dut_a (
      .clock       (clk),
      .reset       (rst_n),
      .enable      (a_en),
      .clear       (a_clr),
      .input_valid (a_v),
      .data_in     (a_din),
      .data_delayed(a_del),
      .output_valid(a_ov),
      .sum_out     (a_sum),
      .mean_out    (a_mean),
      .window_full (a_wf)
   );

   window_average #(.DATA_WIDTH(DW), .WINDOW_SHIFT(SB)) u_dut_b (
      .clock       (clk),
      .reset       (rst_n),
      .enable      (b_en),
      .clear       (b_clr),
      .input_valid (b_v),
      .data_in     (b_din),
      .data_delayed(b_del),
      .output_valid(b_ov),
      .sum_out     (b_sum),
      .mean_out    (b_mean),
      .window_full (b_wf)
   );

   int total = 0;
   int bad   = 0;

   // Reference model for instance A: every sample accepted since the last
   // reset/clear, in order.
   longint unsigned hist[$];
   longint unsigned e_sum, e_mean;
   logic            e_ov, e_wf;

   function automatic longint unsigned win_sum();
      longint unsigned s = 0;
      for (int k = hist.size() - NA; k < hist.size(); k++) s += hist[k];
      return s;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      e_sum  = 0;
      e_mean = 0;
      e_ov   = 1'b0;
      e_wf   = 1'b0;
   endtask

   task automatic check_a(input string tag);
      chk({tag, "_sum"},  64'(a_sum),  64'(e_sum));
      chk({tag, "_mean"}, 64'(a_mean), 64'(e_mean));
      chk({tag, "_ov"},   64'(a_ov),   64'(e_ov));
      chk({tag, "_wf"},   64'(a_wf),   64'(e_wf));
   endtask

   // One clock of instance A: drive, advance the model, check after the edge.
   task automatic step_a(input logic en, input logic clr, input logic v,
                         input logic [DW-1:0] din, input string tag);
      a_en  = en;
      a_clr = clr;
      a_v   = v;
      a_din = din;
      if (hist.size() >= NA) a_del = DW'(hist[hist.size() - NA]);
      else                   a_del = $urandom();
      @(posedge clk);
      e_ov = 1'b0;
      if (en) begin
         if (clr) begin
            hist.delete();
            e_wf = 1'b0;
         end else if (v) begin
            hist.push_back(longint'(din));
            if (hist.size() >= NA) begin
               e_sum  = win_sum();
               e_mean = e_sum >> SA;
               e_ov   = 1'b1;
               e_wf   = 1'b1;
            end
         end
      end
      #1;
      check_a(tag);
   endtask

   task automatic check_b_zero(input string tag);
      chk({tag, "_b_sum"},  64'(b_sum),  64'd0);
      chk({tag, "_b_mean"}, 64'(b_mean), 64'd0);
      chk({tag, "_b_ov"},   64'(b_ov),   64'd0);
      chk({tag, "_b_wf"},   64'(b_wf),   64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      a_en = 1'b0; a_clr = 1'b0; a_v = 1'b0; a_din = '0; a_del = '0;
      b_en = 1'b0; b_clr = 1'b0; b_v = 1'b0; b_din = '0; b_del = '0;
      model_reset();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_a("reset");
      check_b_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous ramp 1..5
      for (int i = 1; i <= 5; i++) begin
         step_a(1'b1, 1'b0, 1'b1, DW'(i), "ramp");
         if (i == 4) begin
            chk("ramp4_sum",  64'(a_sum),  64'd10);
            chk("ramp4_mean", 64'(a_mean), 64'd2);
            chk("ramp4_wf",   64'(a_wf),   64'd1);
         end
         if (i == 5) begin
            chk("ramp5_sum",  64'(a_sum),  64'd14);
            chk("ramp5_mean", 64'(a_mean), 64'd3);
         end
      end

      // Enable low for 5 cycles with valid data (and one ignored clear)
      for (int i = 0; i < 5; i++)
         step_a(1'b0, (i == 2), 1'b1, $urandom(), "hold");
      chk("hold_sum", 64'(a_sum), 64'd14);
      step_a(1'b1, 1'b0, 1'b1, 32'd6, "resume");
      chk("resume_sum", 64'(a_sum), 64'd18);
      step_a(1'b1, 1'b0, 1'b1, 32'd7, "ramp");
      step_a(1'b1, 1'b0, 1'b1, 32'd8, "ramp");

      // Clear wins over a coincident valid sample; refill with fresh data
      step_a(1'b1, 1'b1, 1'b1, 32'd99, "clear");
      chk("clear_sum_hold", 64'(a_sum), 64'd26);
      step_a(1'b1, 1'b0, 1'b1, 32'd100, "refill");
      step_a(1'b1, 1'b0, 1'b1, 32'd200, "refill");
      step_a(1'b1, 1'b0, 1'b1, 32'd300, "refill");
      step_a(1'b1, 1'b0, 1'b1, 32'd400, "refill");
      chk("refill_sum", 64'(a_sum), 64'd1000);
      chk("refill_ov",  64'(a_ov),  64'd1);

      // Ramp with input_valid on every other cycle
      step_a(1'b1, 1'b1, 1'b0, 32'd0, "clear2");
      for (int i = 1; i <= 12; i++) begin
         step_a(1'b1, 1'b0, 1'b1, DW'(i), "toggle_v");
         step_a(1'b1, 1'b0, 1'b0, $urandom(), "toggle_i");
      end
      chk("toggle_sum", 64'(a_sum), 64'd42);

      // Asynchronous reset between clock edges while in RUN
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_a("async_rst");
      check_b_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++)
         step_a(1'b1, 1'b0, 1'b1, DW'(i), "post_rst");
      chk("post_rst_sum", 64'(a_sum), 64'd14);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step_a(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 7), $urandom(), "rand");

      // Instance B: full-scale constant input over a 512-beat window
      a_en = 1'b0;
      for (int i = 1; i <= NB + 88; i++) begin
         b_en  = 1'b1;
         b_clr = 1'b0;
         b_v   = 1'b1;
         b_din = 32'hFFFF_FFFF;
         b_del = (i > NB) ? 32'hFFFF_FFFF : $urandom();
         @(posedge clk);
         #1;
         if (i < NB) begin
            chk("b_fill_ov",  64'(b_ov),  64'd0);
            chk("b_fill_wf",  64'(b_wf),  64'd0);
            chk("b_fill_sum", 64'(b_sum), 64'd0);
         end else begin
            chk("b_run_ov",   64'(b_ov),   64'd1);
            chk("b_run_wf",   64'(b_wf),   64'd1);
            chk("b_run_sum",  64'(b_sum),  64'h1FF_FFFF_FE00);
            chk("b_run_mean", 64'(b_mean), 64'hFFFF_FFFF);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
